// File: rtl/bcd_defs_pkg.sv
// bcd_defs_pkg: shared BCD digit constants and nibble validity check.
package bcd_defs_pkg;
    localparam int BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_MAX = 4'd9;
    localparam logic [BCD_DIGIT_W-1:0] BCD_MIN = 4'd0;

    function automatic logic bcd_nibble_valid(input logic [BCD_DIGIT_W-1:0] n);
        return n <= BCD_MAX;
    endfunction
endpackage

// File: rtl/bcd_digit_step.sv
// bcd_digit_step: one BCD digit step with ripple carry/borrow.
// Down counting exists only when BCD_UPDOWN_EN is defined.
module bcd_digit_step
    import bcd_defs_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    input  logic                   cin_i,
`ifdef BCD_UPDOWN_EN
    input  logic                   dir_i,
`endif
    output logic [BCD_DIGIT_W-1:0] digit_o,
    output logic                   cout_o
);
`ifdef BCD_UPDOWN_EN
    logic term;
    assign term    = dir_i ? (digit_i == BCD_MIN) : (digit_i == BCD_MAX);
    assign cout_o  = cin_i && term;
    assign digit_o = !cin_i ? digit_i :
                     dir_i  ? (term ? BCD_MAX : digit_i - 4'd1) :
                              (term ? BCD_MIN : digit_i + 4'd1);
`else
    logic term;
    assign term    = digit_i == BCD_MAX;
    assign cout_o  = cin_i && term;
    assign digit_o = !cin_i ? digit_i : (term ? BCD_MIN : digit_i + 4'd1);
`endif
endmodule

// File: rtl/bcd_counter_n.sv
// bcd_counter_n: registered N-digit packed-BCD counter with load, wrap/saturate and flags.
// Define BCD_UPDOWN_EN to add the dir port and down counting.
module bcd_counter_n
    import bcd_defs_pkg::*;
#(
    parameter int DIGITS  = 3,
    parameter bit WRAP_EN = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load,
    input  logic [DIGITS*BCD_DIGIT_W-1:0] bcd_in,
    input  logic                          inc,
`ifdef BCD_UPDOWN_EN
    input  logic                          dir,
`endif
    output logic [DIGITS*BCD_DIGIT_W-1:0] bcd_out,
    output logic                          carry_out,
    output logic                          at_max,
    output logic                          load_err
);
    localparam int W = DIGITS * BCD_DIGIT_W;

    logic [W-1:0]      bcd_q, bcd_d, step;
    logic [DIGITS:0]   c;
    logic [DIGITS-1:0] in_ok, is_max;
    logic              carry_q, carry_d, err_q, err_d, load_ok;

    assign c[0] = inc;

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        bcd_digit_step u_step (
            .digit_i (bcd_q[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .cin_i   (c[i]),
`ifdef BCD_UPDOWN_EN
            .dir_i   (dir),
`endif
            .digit_o (step[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .cout_o  (c[i+1])
        );
        assign in_ok[i]  = bcd_nibble_valid(bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
        assign is_max[i] = bcd_q[i*BCD_DIGIT_W +: BCD_DIGIT_W] == BCD_MAX;
    end

    // carry out of the top digit means the step crossed a terminal value
    always_comb begin
        load_ok = &in_ok;
        bcd_d   = load ? (load_ok ? bcd_in : bcd_q) :
                  (c[DIGITS] && !WRAP_EN) ? bcd_q : step;
        carry_d = !load && c[DIGITS];
        err_d   = load && !load_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            bcd_q   <= bcd_d;
            carry_q <= carry_d;
            err_q   <= err_d;
        end
    end

    assign bcd_out   = bcd_q;
    assign carry_out = carry_q;
    assign load_err  = err_q;
    assign at_max    = &is_max;
endmodule
